// File: rtl/timer_irq_source.sv
// Memory-mapped interval timer: TH reload, TL counter, TCON control/status, registered IRQ.
// Define TIMER_PRESCALE_EN to add the PSC prescaler register at offset 0x0C.
module timer_irq_source #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] RESET_TH  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        IRQ
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        st_q, st_d;
  logic        irq_q, irq_d;

  logic [1:0]  regSel;
  logic        wrTh, wrTl, wrTcon;
  logic        tick, wrap;
  logic [31:0] rdMux;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^Address[1:0];

  always_comb begin
    Hit    = (Address[31:4] == BASE_ADDR[31:4]);
    regSel = Address[3:2];
    wrTh   = MemWrite && Hit && (regSel == 2'd0);
    wrTl   = MemWrite && Hit && (regSel == 2'd1);
    wrTcon = MemWrite && Hit && (regSel == 2'd2);
  end

`ifdef TIMER_PRESCALE_EN
  logic [15:0] psc_q, psc_d;
  logic [15:0] pscCnt_q, pscCnt_d;
  logic        wrPsc;

  assign wrPsc = MemWrite && Hit && (regSel == 2'd3);
  assign tick  = en_q && (pscCnt_q == psc_q);

  always_comb begin
    psc_d    = wrPsc ? WriteData[15:0] : psc_q;
    pscCnt_d = pscCnt_q + 16'd1;
    if (wrPsc || wrTl || !en_q || (pscCnt_q == psc_q)) begin
      pscCnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_q    <= 16'd0;
      pscCnt_q <= 16'd0;
    end else begin
      psc_q    <= psc_d;
      pscCnt_q <= pscCnt_d;
    end
  end
`else
  assign tick = en_q;
`endif

  assign wrap = tick && (tl_q == 32'hFFFF_FFFF);

  // A TL write overrides both increment and reload; a wrap's status set beats a TCON clear.
  always_comb begin
    th_d  = wrTh ? WriteData : th_q;
    tl_d  = tl_q;
    en_d  = en_q;
    ie_d  = ie_q;
    st_d  = st_q;
    irq_d = st_q;
    if (wrTl) begin
      tl_d = WriteData;
    end else if (wrap) begin
      tl_d = th_q;
    end else if (tick) begin
      tl_d = tl_q + 32'd1;
    end
    if (wrTcon) begin
      en_d = WriteData[0];
      ie_d = WriteData[1];
      st_d = WriteData[2];
    end
    if (wrap && ie_q && !wrTl) begin
      st_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q  <= RESET_TH;
      tl_q  <= 32'd0;
      en_q  <= 1'b0;
      ie_q  <= 1'b0;
      st_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      th_q  <= th_d;
      tl_q  <= tl_d;
      en_q  <= en_d;
      ie_q  <= ie_d;
      st_q  <= st_d;
      irq_q <= irq_d;
    end
  end

  always_comb begin
    rdMux = 32'd0;
    case (regSel)
      2'd0: rdMux = th_q;
      2'd1: rdMux = tl_q;
      2'd2: rdMux = {29'd0, st_q, ie_q, en_q};
`ifdef TIMER_PRESCALE_EN
      2'd3: rdMux = {16'd0, psc_q};
`endif
      default: rdMux = 32'd0;
    endcase
    ReadData = (MemRead && Hit) ? rdMux : 32'd0;
  end

  assign IRQ = irq_q;

endmodule
